xbar_traverse: RTL and testbench



---
 rtl/xbar_traverse_pkg.sv | 30 +++
 rtl/xbar_traverse_if.sv | 35 +++
 rtl/xbar_traverse_out_port_mux.sv | 35 +++
 rtl/xbar_traverse.sv | 157 +++++++++++++++
 tb/tb_xbar_traverse.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_traverse_pkg.sv
// Shared router constants and small helpers for the crossbar traversal stage.
// Holds the port count, default widths and the rank/port vector types.
package xbar_traverse_pkg;

  localparam int NUM_PORT   = 5;
  localparam int FLIT_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  // Wide enough to hold 0..NUM_PORT (claims on one port, deflections per cycle).
  localparam int CLAIM_W = $clog2(NUM_PORT + 1);

  typedef logic [NUM_PORT-1:0] portVec_t;
  typedef logic [CLAIM_W-1:0]  claim_t;

  // Keep only the lowest set bit, so a multi-hot allocation degrades to one port.
  function automatic portVec_t lowestOneHot(input portVec_t v);
    return v & (~v + portVec_t'(1));
  endfunction

  // Number of set bits in a port vector.
  function automatic claim_t popCount(input portVec_t v);
    claim_t c;
    c = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      c = c + claim_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/xbar_traverse_if.sv
// Crossbar traversal bus: ranked flits with their port vectors in, one
// registered flit per output port out. The master drives flits, the slave
// (the crossbar) drives the outputs.
interface xbar_traverse_if
  import xbar_traverse_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF
) ();

  logic [FLIT_W-1:0] flit_in_0, flit_in_1, flit_in_2, flit_in_3, flit_in_4;
  portVec_t          valid_in;
  portVec_t          ppv_0, ppv_1, ppv_2, ppv_3, ppv_4;
  portVec_t          allocPV_0, allocPV_1, allocPV_2, allocPV_3, allocPV_4;
  logic [FLIT_W-1:0] flit_out_0, flit_out_1, flit_out_2, flit_out_3, flit_out_4;
  portVec_t          valid_out;

  modport master (
    output flit_in_0, flit_in_1, flit_in_2, flit_in_3, flit_in_4,
    output valid_in,
    output ppv_0, ppv_1, ppv_2, ppv_3, ppv_4,
    output allocPV_0, allocPV_1, allocPV_2, allocPV_3, allocPV_4,
    input  flit_out_0, flit_out_1, flit_out_2, flit_out_3, flit_out_4,
    input  valid_out
  );

  modport slave (
    input  flit_in_0, flit_in_1, flit_in_2, flit_in_3, flit_in_4,
    input  valid_in,
    input  ppv_0, ppv_1, ppv_2, ppv_3, ppv_4,
    input  allocPV_0, allocPV_1, allocPV_2, allocPV_3, allocPV_4,
    output flit_out_0, flit_out_1, flit_out_2, flit_out_3, flit_out_4,
    output valid_out
  );

endinterface

// File: rtl/xbar_traverse_out_port_mux.sv
// out_port_mux: priority select over ranks for a single output port.
// The lowest valid rank whose (already one-hot) allocation hits this port
// wins; claimCnt reports how many valid ranks asked for the port so the
// top level can flag collisions.
module out_port_mux
  import xbar_traverse_pkg::*;
#(
  parameter int FLIT_W   = FLIT_W_DEF,
  parameter int PORT_IDX = 0
) (
  input  portVec_t          validIn,
  input  portVec_t          effAlloc [NUM_PORT],
  input  logic [FLIT_W-1:0] flitIn   [NUM_PORT],
  output logic              selValid,
  output logic [FLIT_W-1:0] selFlit,
  output claim_t            claimCnt
);

  // Scan from the youngest rank down so the oldest claimant is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path that
    // never hits an assignment would infer a latch.
    selValid = 1'b0;
    selFlit  = '0;
    claimCnt = '0;
    for (int r = NUM_PORT - 1; r >= 0; r--) begin
      if (validIn[r] && effAlloc[r][PORT_IDX]) begin
        selValid = 1'b1;
        selFlit  = flitIn[r];
        claimCnt = claimCnt + claim_t'(1);
      end
    end
  end

endmodule

// File: rtl/xbar_traverse.sv
// xbar_traverse: single-cycle crossbar traversal stage.
// Each output port registers the flit of the oldest valid rank allocated to
// it; sticky flags record port collisions / multi-hot allocations and
// dropped flits. Optional feature macro DEFLECT_STAT_EN adds a saturating
// count of deflected flits; without it deflect_cnt is a constant 0.
module xbar_traverse
  import xbar_traverse_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  xbar_traverse_if.slave     bus,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   deflect_cnt,
  output logic               conflict_err,
  output logic               drop_err
);

  logic [FLIT_W-1:0] flitIn   [NUM_PORT];
  portVec_t          allocPv  [NUM_PORT];
  portVec_t          effAlloc [NUM_PORT];
  portVec_t          validIn;

  logic [FLIT_W-1:0] portFlit [NUM_PORT];
  portVec_t          portValid;
  claim_t            claimCnt [NUM_PORT];

  logic [FLIT_W-1:0] flitOut  [NUM_PORT];
  portVec_t          validOut;

  logic              conflictEv;
  logic              dropEv;

  assign flitIn[0] = bus.flit_in_0;
  assign flitIn[1] = bus.flit_in_1;
  assign flitIn[2] = bus.flit_in_2;
  assign flitIn[3] = bus.flit_in_3;
  assign flitIn[4] = bus.flit_in_4;

  assign allocPv[0] = bus.allocPV_0;
  assign allocPv[1] = bus.allocPV_1;
  assign allocPv[2] = bus.allocPV_2;
  assign allocPv[3] = bus.allocPV_3;
  assign allocPv[4] = bus.allocPV_4;

  assign validIn = bus.valid_in;

  // Reduce each allocation to its lowest set bit and collect per-rank error events.
  always_comb begin
    dropEv     = 1'b0;
    conflictEv = 1'b0;
    for (int r = 0; r < NUM_PORT; r++) begin
      effAlloc[r] = lowestOneHot(allocPv[r]);
      if (validIn[r]) begin
        if (allocPv[r] == '0)          dropEv     = 1'b1;
        if (allocPv[r] != effAlloc[r]) conflictEv = 1'b1;
      end
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      if (claimCnt[p] > claim_t'(1)) conflictEv = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    out_port_mux #(
      .FLIT_W   (FLIT_W),
      .PORT_IDX (p)
    ) uMux (
      .validIn  (validIn),
      .effAlloc (effAlloc),
      .flitIn   (flitIn),
      .selValid (portValid[p]),
      .selFlit  (portFlit[p]),
      .claimCnt (claimCnt[p])
    );
  end

  // Output registers: valid follows the select every cycle, flits only load when valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value regardless of statement order.
      validOut <= '0;
      for (int p = 0; p < NUM_PORT; p++) flitOut[p] <= '0;
    end else begin
      validOut <= portValid;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (portValid[p]) flitOut[p] <= portFlit[p];
      end
    end
  end

  assign bus.valid_out  = validOut;
  assign bus.flit_out_0 = flitOut[0];
  assign bus.flit_out_1 = flitOut[1];
  assign bus.flit_out_2 = flitOut[2];
  assign bus.flit_out_3 = flitOut[3];
  assign bus.flit_out_4 = flitOut[4];

  // Sticky error flags; a clear in the same cycle discards that cycle's events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_err <= 1'b0;
      drop_err     <= 1'b0;
    end else if (stat_clr) begin
      conflict_err <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      if (conflictEv) conflict_err <= 1'b1;
      if (dropEv)     drop_err     <= 1'b1;
    end
  end

`ifdef DEFLECT_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  portVec_t         deflectHit;
  claim_t           deflectNum;
  logic [CNT_W-1:0] deflectCnt;
  logic [CNT_W:0]   cntSum;

  // A valid, allocated flit is deflected when none of its allocated ports is productive.
  always_comb begin
    for (int r = 0; r < NUM_PORT; r++) begin
      deflectHit[r] = validIn[r] && (allocPv[r] != '0)
                   && ((allocPv[r] & bus.ppv_0) == '0);
    end
    deflectHit[1] = validIn[1] && (allocPv[1] != '0) && ((allocPv[1] & bus.ppv_1) == '0);
    deflectHit[2] = validIn[2] && (allocPv[2] != '0) && ((allocPv[2] & bus.ppv_2) == '0);
    deflectHit[3] = validIn[3] && (allocPv[3] != '0) && ((allocPv[3] & bus.ppv_3) == '0);
    deflectHit[4] = validIn[4] && (allocPv[4] != '0) && ((allocPv[4] & bus.ppv_4) == '0);
  end

  assign deflectNum = popCount(deflectHit);
  assign cntSum     = {1'b0, deflectCnt} + (CNT_W + 1)'(deflectNum);

  // Saturating deflection counter; the carry bit of the sum signals overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deflectCnt <= '0;
    end else if (stat_clr) begin
      deflectCnt <= '0;
    end else if (cntSum[CNT_W]) begin
      deflectCnt <= CNT_MAX;
    end else begin
      deflectCnt <= cntSum[CNT_W-1:0];
    end
  end

  assign deflect_cnt = deflectCnt;
`else
  assign deflect_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_traverse.sv
// Directed bench for xbar_traverse. A behavioural model predicts each cycle's
// outputs into a scoreboard queue when stimulus is driven; the entry is popped
// and compared one clock later. Counter expectations follow DEFLECT_STAT_EN.
module tb_xbar_traverse;
  import xbar_traverse_pkg::*;

  localparam int FW = 64;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          stat_clr;
  logic [CW-1:0] deflect_cnt;
  logic          conflict_err;
  logic          drop_err;

  xbar_traverse_if #(.FLIT_W(FW)) bus ();

  xbar_traverse #(.FLIT_W(FW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stat_clr     (stat_clr),
    .deflect_cnt  (deflect_cnt),
    .conflict_err (conflict_err),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][FW-1:0] flit;
    logic [4:0]         valid;
    logic               conf;
    logic               drop;
    logic [CW-1:0]      cnt;
  } exp_t;

  exp_t       sbQ[$];
  exp_t       model;
  logic [FW-1:0] tFlit [5];
  logic [4:0]    tValid;
  logic [4:0]    tPpv   [5];
  logic [4:0]    tAlloc [5];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowIdx(input logic [4:0] v);
    for (int b = 0; b < 5; b++) if (v[b]) return b;
    return -1;
  endfunction

  function automatic logic [FW-1:0] outFlit(input int p);
    case (p)
      0:       return bus.flit_out_0;
      1:       return bus.flit_out_1;
      2:       return bus.flit_out_2;
      3:       return bus.flit_out_3;
      default: return bus.flit_out_4;
    endcase
  endfunction

  task automatic drive();
    bus.flit_in_0 = tFlit[0]; bus.flit_in_1 = tFlit[1]; bus.flit_in_2 = tFlit[2];
    bus.flit_in_3 = tFlit[3]; bus.flit_in_4 = tFlit[4];
    bus.ppv_0 = tPpv[0]; bus.ppv_1 = tPpv[1]; bus.ppv_2 = tPpv[2];
    bus.ppv_3 = tPpv[3]; bus.ppv_4 = tPpv[4];
    bus.allocPV_0 = tAlloc[0]; bus.allocPV_1 = tAlloc[1]; bus.allocPV_2 = tAlloc[2];
    bus.allocPV_3 = tAlloc[3]; bus.allocPV_4 = tAlloc[4];
    bus.valid_in = tValid;
  endtask

  task automatic setIdle();
    tValid = '0;
    for (int r = 0; r < 5; r++) begin
      tAlloc[r] = '0;
      tPpv[r]   = '0;
    end
  endtask

  task automatic newFlits();
    for (int r = 0; r < 5; r++) tFlit[r] = {$urandom, $urandom};
  endtask

  // Model of one capture edge: routing by oldest claimant, sticky flags, counter.
  task automatic predict(input logic clr);
    exp_t nx;
    int   li [5];
    int   defl;
    int   sum;
    logic conf;
    logic drop;
    nx   = model;
    defl = 0;
    conf = 1'b0;
    drop = 1'b0;
    for (int r = 0; r < 5; r++) begin
      li[r] = tValid[r] ? lowIdx(tAlloc[r]) : -1;
      if (tValid[r]) begin
        if ($countones(tAlloc[r]) > 1) conf = 1'b1;
        if (tAlloc[r] == '0) drop = 1'b1;
        else if ((tAlloc[r] & tPpv[r]) == '0) defl++;
      end
    end
    for (int r = 0; r < 5; r++)
      for (int s = r + 1; s < 5; s++)
        if (li[r] >= 0 && li[r] == li[s]) conf = 1'b1;
    nx.valid = '0;
    for (int p = 0; p < 5; p++) begin
      for (int r = 0; r < 5; r++) begin
        if (li[r] == p && !nx.valid[p]) begin
          nx.valid[p] = 1'b1;
          nx.flit[p]  = tFlit[r];
        end
      end
    end
    if (clr) begin
      nx.conf = 1'b0;
      nx.drop = 1'b0;
      nx.cnt  = '0;
    end else begin
      nx.conf = model.conf | conf;
      nx.drop = model.drop | drop;
`ifdef DEFLECT_STAT_EN
      sum    = int'(model.cnt) + defl;
      nx.cnt = (sum > CNT_MAX) ? CW'(CNT_MAX) : CW'(sum);
`else
      sum    = defl;
      nx.cnt = '0;
`endif
    end
    model = nx;
    sbQ.push_back(nx);
  endtask

  task automatic compareOut();
    exp_t e;
    check("sb_nonempty", FW'(sbQ.size() > 0), FW'(1));
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check("valid_out",    FW'(bus.valid_out), FW'(e.valid));
      check("conflict_err", FW'(conflict_err),  FW'(e.conf));
      check("drop_err",     FW'(drop_err),      FW'(e.drop));
      check("deflect_cnt",  FW'(deflect_cnt),   FW'(e.cnt));
      for (int p = 0; p < 5; p++) check($sformatf("flit_out_%0d", p), outFlit(p), e.flit[p]);
    end
  endtask

  task automatic step(input logic clr);
    predict(clr);
    stat_clr = clr;
    drive();
    @(posedge clk);
    #1;
    compareOut();
  endtask

  task automatic resetModel();
    model = '0;
    sbQ.delete();
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_valid"}, FW'(bus.valid_out), '0);
    check({tag, "_conf"},  FW'(conflict_err),  '0);
    check({tag, "_drop"},  FW'(drop_err),      '0);
    check({tag, "_cnt"},   FW'(deflect_cnt),   '0);
    for (int p = 0; p < 5; p++) check($sformatf("%s_flit%0d", tag, p), outFlit(p), '0);
  endtask

  initial begin
    reset    = 1'b0;
    stat_clr = 1'b0;
    for (int r = 0; r < 5; r++) tFlit[r] = '0;
    setIdle();
    drive();
    resetModel();
    #2;
    checkReset("rst_init");
    @(negedge clk);
    reset = 1'b1;

    // All ranks straight through on their own productive port.
    newFlits();
    tValid = 5'b11111;
    for (int r = 0; r < 5; r++) begin
      tAlloc[r] = 5'(1 << r);
      tPpv[r]   = 5'(1 << r);
    end
    step(1'b0);
    check("straight_flit3", bus.flit_out_3, tFlit[3]);

    // Idle: valids drop, flits hold.
    setIdle();
    step(1'b0);

    // Two ranks on port 2: rank 0 wins, conflict sticky over idle cycles.
    newFlits();
    tValid    = 5'b00011;
    tAlloc[0] = 5'b00100; tPpv[0] = 5'b00100;
    tAlloc[1] = 5'b00100; tPpv[1] = 5'b00100;
    step(1'b0);
    check("conflict_winner", bus.flit_out_2, tFlit[0]);
    setIdle();
    step(1'b0);
    step(1'b0);
    step(1'b1);

    // Multi-hot allocation: forwarded only on lowest bit, conflict raised.
    newFlits();
    tValid    = 5'b00001;
    tAlloc[0] = 5'b01010; tPpv[0] = 5'b00010;
    step(1'b0);
    setIdle();
    step(1'b1);

    // Three cycles of a single deflected flit.
    tValid    = 5'b00001;
    tAlloc[0] = 5'b01000; tPpv[0] = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      newFlits();
      step(1'b0);
    end
`ifdef DEFLECT_STAT_EN
    check("deflect_three", FW'(deflect_cnt), FW'(3));
`else
    check("deflect_off", FW'(deflect_cnt), FW'(0));
`endif

    // Drop with coincident clear is not recorded; without clear it is.
    newFlits();
    tValid    = 5'b00001;
    tAlloc[0] = 5'b00000; tPpv[0] = 5'b00001;
    step(1'b1);
    step(1'b0);
    check("drop_set", FW'(drop_err), FW'(1));

    // Random traffic, including invalid ranks with junk vectors.
    for (int i = 0; i < 24; i++) begin
      newFlits();
      tValid = 5'($urandom);
      for (int r = 0; r < 5; r++) begin
        tAlloc[r] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
        tPpv[r]   = 5'($urandom);
      end
      step((i % 8) == 7);
    end

    // Reset asserted between edges during traffic.
    newFlits();
    tValid = 5'b00001;
    tAlloc[0] = '0;
    step(1'b0);
    newFlits();
    tValid = 5'b11111;
    for (int r = 0; r < 5; r++) begin
      tAlloc[r] = 5'(1 << r);
      tPpv[r]   = 5'(1 << ((r + 1) % 5));
    end
    step(1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkReset("rst_async");
    resetModel();
    @(posedge clk);
    #1;
    checkReset("rst_held");
    @(negedge clk);
    reset = 1'b1;
    step(1'b0);

`ifdef DEFLECT_STAT_EN
    // Drive the counter to 0xFFFE with five deflections per cycle, then saturate.
    step(1'b1);
    tValid = 5'b11111;
    for (int r = 0; r < 5; r++) begin
      tAlloc[r] = 5'(1 << r);
      tPpv[r]   = ~5'(1 << r);
    end
    for (int i = 0; i < 13106; i++) step(1'b0);
    tValid = 5'b01111;
    step(1'b0);
    check("cnt_preload", FW'(deflect_cnt), FW'(16'hFFFE));
    tValid = 5'b11111;
    step(1'b0);
    check("cnt_sat", FW'(deflect_cnt), FW'(16'hFFFF));
    step(1'b0);
    check("cnt_sat_hold", FW'(deflect_cnt), FW'(16'hFFFF));
`endif

    setIdle();
    step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
